// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
// slave is the arbiter's view; master is the view of the CPU ports plus the memory.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rdata;
   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata, m_wstrb, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata, m_wstrb, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and load/store ports.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise data has fixed priority.
module mem_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        owner_q;
   logic        we_q;
   logic        i_rvalid_q;
   logic        d_rvalid_q;
   logic        busy_q;
   logic        m_en_q;
   logic        m_we_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [3:0]  m_wstrb_q;
   logic        grant_ok_d;
   logic        pick_d_d;
   logic        i_gnt_d;
   logic        d_gnt_d;
`ifdef ARB_RR_EN
   logic        last_d_q;
`endif

   // Grant decision; gated by reset so no grant is visible while reset is held.
   always_comb begin
      grant_ok_d = reset && ((state_q == IDLE) || (state_q == RESP));
`ifdef ARB_RR_EN
      pick_d_d   = bus.d_req && (!bus.i_req || !last_d_q);
`else
      pick_d_d   = bus.d_req;
`endif
      d_gnt_d    = grant_ok_d && pick_d_d;
      i_gnt_d    = grant_ok_d && bus.i_req && !pick_d_d;
   end

   // Transaction FSM with registered memory strobes, response flags and busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         busy_q     <= 1'b0;
         m_en_q     <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= 32'd0;
         m_wdata_q  <= 32'd0;
         m_wstrb_q  <= 4'd0;
`ifdef ARB_RR_EN
         last_d_q   <= 1'b1;
`endif
      end else begin
         m_en_q     <= 1'b0;
         m_we_q     <= 1'b0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (i_gnt_d || d_gnt_d) begin
                  state_q   <= ISSUE;
                  busy_q    <= 1'b1;
                  m_en_q    <= 1'b1;
                  owner_q   <= d_gnt_d;
                  we_q      <= d_gnt_d && bus.d_we;
                  m_we_q    <= d_gnt_d && bus.d_we;
                  m_addr_q  <= d_gnt_d ? bus.d_addr  : bus.i_addr;
                  m_wdata_q <= d_gnt_d ? bus.d_wdata : 32'd0;
                  m_wstrb_q <= d_gnt_d ? bus.d_wstrb : 4'd0;
`ifdef ARB_RR_EN
                  last_d_q  <= d_gnt_d;
`endif
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ISSUE: begin
               if (MEM_LAT == 1) begin
                  state_q    <= RESP;
                  i_rvalid_q <= !owner_q;
                  d_rvalid_q <= owner_q;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= 4'(MEM_LAT - 2);
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q    <= RESP;
                  i_rvalid_q <= !owner_q;
                  d_rvalid_q <= owner_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read data is not registered: memory data arrives exactly in the RESP cycle.
   assign bus.i_gnt    = i_gnt_d;
   assign bus.d_gnt    = d_gnt_d;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rvalid_q ? bus.m_rdata : 32'd0;
   assign bus.d_rdata  = (d_rvalid_q && !we_q) ? bus.m_rdata : 32'd0;
   assign bus.m_en     = m_en_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.m_wstrb  = m_wstrb_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized legal traffic.
module tb_mem_arbiter;
   localparam int LAT = 2;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   mem_arbiter_if bus ();
   mem_arbiter_if bus1 ();

   mem_arbiter #(.MEM_LAT(LAT)) dut  (.clk(clk), .reset(reset), .bus(bus));
   mem_arbiter #(.MEM_LAT(1))   dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Memory: data for an access is valid exactly LAT cycles after its m_en cycle, junk otherwise.
   logic        en_h [1:15];
   logic [31:0] ad_h [1:15];
   logic        en_now, en1_now;
   logic [31:0] ad_now, ad1_now;
   initial begin
      for (int k = 1; k <= 15; k++) begin
         en_h[k] = 1'b0;
         ad_h[k] = 32'd0;
      end
      bus.m_rdata  = 32'd0;
      bus1.m_rdata = 32'd0;
      forever begin
         @(negedge clk);
         en_now  = bus.m_en;
         ad_now  = bus.m_addr;
         en1_now = bus1.m_en;
         ad1_now = bus1.m_addr;
         @(posedge clk);
         #1;
         for (int k = 15; k > 1; k--) begin
            en_h[k] = en_h[k-1];
            ad_h[k] = ad_h[k-1];
         end
         en_h[1] = en_now;
         ad_h[1] = ad_now;
         bus.m_rdata  = en_h[LAT] ? memf(ad_h[LAT]) : $urandom;
         bus1.m_rdata = en1_now ? memf(ad1_now) : $urandom;
      end
   end

   // Reference model: one outstanding transaction described by its grant cycle and payload.
   bit          inflight = 1'b0;
   int          tg = 0;
   bit          own_t, we_t, last_d;
   logic [31:0] addr_t, wdata_t, maddr_e;
   logic [3:0]  mwstrb_e;
   always @(negedge clk) begin : compare
      bit resp, issue, can, pick_d, e_ig, e_dg;
      if (inflight && (cyc > tg + 1 + LAT)) inflight = 1'b0;
      if (!reset) begin
         inflight = 1'b0;
         last_d   = 1'b1;
         maddr_e  = 32'd0;
         mwstrb_e = 4'd0;
      end
      resp   = inflight && (cyc == tg + 1 + LAT);
      issue  = inflight && (cyc == tg + 1);
      can    = reset && (!inflight || resp);
      pick_d = bus.d_req && (!bus.i_req || (RR ? !last_d : 1'b1));
      e_dg   = can && pick_d;
      e_ig   = can && bus.i_req && !pick_d;
      chk("i_gnt",    bus.i_gnt,    e_ig);
      chk("d_gnt",    bus.d_gnt,    e_dg);
      chk("m_en",     bus.m_en,     issue);
      chk("m_we",     bus.m_we,     issue && we_t);
      chk("m_addr",   bus.m_addr,   maddr_e);
      chk("m_wstrb",  bus.m_wstrb,  mwstrb_e);
      if (issue && we_t) chk("m_wdata", bus.m_wdata, wdata_t);
      chk("busy",     bus.busy,     inflight);
      chk("i_rvalid", bus.i_rvalid, resp && !own_t);
      chk("d_rvalid", bus.d_rvalid, resp && own_t);
      chk("i_rdata",  bus.i_rdata,  (resp && !own_t) ? memf(addr_t) : 32'd0);
      chk("d_rdata",  bus.d_rdata,  (resp && own_t && !we_t) ? memf(addr_t) : 32'd0);
      if (e_ig || e_dg) begin
         inflight = 1'b1;
         tg       = cyc;
         own_t    = e_dg;
         we_t     = e_dg && bus.d_we;
         addr_t   = e_dg ? bus.d_addr : bus.i_addr;
         wdata_t  = bus.d_wdata;
         maddr_e  = addr_t;
         mwstrb_e = e_dg ? bus.d_wstrb : 4'd0;
         last_d   = e_dg;
      end
      cyc++;
   end

   int ngr;
   bit e_d, p_d, ig, dg;
   initial begin
      reset = 1'b0;
      bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0010;
      bus.d_req = 1'b1;  bus.d_we = 1'b1;  bus.d_addr = 32'h0000_0020;
      bus.d_wdata = 32'd0; bus.d_wstrb = 4'hF;
      bus1.i_req = 1'b0; bus1.i_addr = 32'd0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      bus1.d_addr = 32'd0; bus1.d_wdata = 32'd0; bus1.d_wstrb = 4'd0;

      // Reset state, with both requests present.
      @(negedge clk);
      chk("rst_i_gnt", bus.i_gnt, 32'd0);
      chk("rst_d_gnt", bus.d_gnt, 32'd0);
      chk("rst_busy",  bus.busy,  32'd0);
      chk("rst_m_addr", bus.m_addr, 32'd0);
      next();
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      reset = 1'b1;
      next();

      // Single fetch at 0x100.
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
      @(negedge clk); chk("f_gnt", bus.i_gnt, 32'd1);
      next(); bus.i_req = 1'b0;
      @(negedge clk);
      chk("f_m_en", bus.m_en, 32'd1); chk("f_m_we", bus.m_we, 32'd0);
      chk("f_m_addr", bus.m_addr, 32'h0000_0100); chk("f_busy1", bus.busy, 32'd1);
      next(); @(negedge clk); chk("f_busy2", bus.busy, 32'd1);
      next(); @(negedge clk);
      chk("f_rvalid", bus.i_rvalid, 32'd1); chk("f_rdata", bus.i_rdata, 32'hDEAD_BEEF);
      chk("f_busy3", bus.busy, 32'd1);
      next(); @(negedge clk); chk("f_busy4", bus.busy, 32'd0);
      next();

      // Store.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0040;
      bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;
      @(negedge clk); chk("s_gnt", bus.d_gnt, 32'd1);
      next(); bus.d_req = 1'b0; bus.d_we = 1'b0;
      @(negedge clk);
      chk("s_m_en", bus.m_en, 32'd1); chk("s_m_we", bus.m_we, 32'd1);
      chk("s_m_addr", bus.m_addr, 32'h0000_0040); chk("s_m_wdata", bus.m_wdata, 32'h1234_5678);
      chk("s_m_wstrb", bus.m_wstrb, 32'hF);
      next(); next(); @(negedge clk);
      chk("s_rvalid", bus.d_rvalid, 32'd1); chk("s_rdata", bus.d_rdata, 32'd0);
      chk("s_i_rvalid", bus.i_rvalid, 32'd0);
      next(); next();

      // Continuous conflict for 20 cycles.
      bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
      for (int k = 0; k < 20; k++) begin
         e_d = RR ? ((k / 3) % 2 == 1) : 1'b1;
         p_d = RR ? (((k - 3) / 3) % 2 == 1) : 1'b1;
         @(negedge clk);
         chk("c_d_gnt", bus.d_gnt, (k % 3 == 0) && e_d);
         chk("c_i_gnt", bus.i_gnt, (k % 3 == 0) && !e_d);
         if (k >= 3 && k % 3 == 0) begin
            chk("c_d_rv", bus.d_rvalid, p_d);
            chk("c_i_rv", bus.i_rvalid, !p_d);
         end
         next();
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      repeat (4) next();

      // Reset during the WAIT of a load.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0080;
      @(negedge clk); chk("r_gnt", bus.d_gnt, 32'd1);
      next(); bus.d_req = 1'b0;
      next(); reset = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h0000_0180;
      @(negedge clk);
      chk("r_busy", bus.busy, 32'd0); chk("r_m_addr", bus.m_addr, 32'd0);
      chk("r_m_wstrb", bus.m_wstrb, 32'd0); chk("r_i_gnt", bus.i_gnt, 32'd0);
      next(); @(negedge clk);
      chk("r_d_rvalid", bus.d_rvalid, 32'd0); chk("r_d_rdata", bus.d_rdata, 32'd0);
      next(); reset = 1'b1;
      @(negedge clk); chk("r_regrant", bus.i_gnt, 32'd1);
      next(); bus.i_req = 1'b0;
      repeat (5) next();

      // MEM_LAT=1 back-to-back fetches on the second instance.
      ngr = 0;
      for (int k = 0; k < 8; k++) begin
         bus1.i_req = (ngr < 3); bus1.i_addr = 32'(4 * ngr);
         @(negedge clk);
         chk("l1_gnt", bus1.i_gnt, (k == 0 || k == 2 || k == 4));
         chk("l1_m_en", bus1.m_en, (k == 1 || k == 3 || k == 5));
         chk("l1_rvalid", bus1.i_rvalid, (k == 2 || k == 4 || k == 6));
         if (k == 2 || k == 4 || k == 6) chk("l1_rdata", bus1.i_rdata, memf(32'(2 * k - 4)));
         if (bus1.i_gnt) ngr++;
         next();
      end
      bus1.i_req = 1'b0;

      // Randomized legal traffic with occasional reset pulses.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         ig = bus.i_gnt;
         dg = bus.d_gnt;
         next();
         reset = ($urandom_range(0, 299) != 0);
         if (!bus.i_req || ig) begin
            bus.i_req  = ($urandom_range(0, 99) < 60);
            bus.i_addr = $urandom & 32'h0000_0FFC;
         end
         if (!bus.d_req || dg) begin
            bus.d_req   = ($urandom_range(0, 99) < 60);
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom & 32'h0000_0FFC;
            bus.d_wdata = $urandom;
            bus.d_wstrb = 4'($urandom);
         end
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; reset = 1'b1;
      repeat (10) next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, fixed-latency memory between the CPU's instruction-fetch port and its load/store port. This is the step that replaces the separate instruction and data memories with a unified memory. The block accepts at most one transaction at a time and resolves simultaneous requests by fixed data priority or by round-robin. It launches the selected access on registered memory outputs and returns the read data, or a write acknowledge, to the requester that owns the transaction.

## Interface
Parameters:
- MEM_LAT, default 2: cycles from the memory-enable cycle to the cycle in which m_rdata is valid. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_req  in  1  fetch request; held until granted
- i_addr  in  32  fetch byte address; stable while i_req=1
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request; held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse; load data valid, or store complete
- d_rdata  out  32  load data (0 for stores)
- m_en  out  1  memory access strobe (registered)
- m_we  out  1  memory write (registered)
- m_addr  out  32  memory address (registered)
- m_wdata  out  32  memory write data (registered)
- m_wstrb  out  4  memory byte enables (registered)
- m_rdata  in  32  memory read data
- busy  out  1  a transaction is outstanding (state ≠ IDLE)

## Operation
States and transitions:
- IDLE → ISSUE when either request is present.
- ISSUE → WAIT, or → RESP directly if MEM_LAT=1.
- WAIT → RESP after MEM_LAT−1 cycles, counted by a 4-bit down-counter.
- RESP → ISSUE if a request is granted in the same cycle, else → IDLE.

Granting:
- Grants are issued only in IDLE or RESP. Exactly one of i_gnt and d_gnt is asserted in that cycle.
- On the grant edge, the winner's addr, we, wdata and wstrb are latched, along with an owner bit (0 = fetch, 1 = data).
- A fetch grant forces we=0 and wstrb=0.

Memory side:
- In ISSUE, m_en=1 and m_* carry the latched values.
- In all other states m_en=0 and m_we=0. m_addr, m_wdata and m_wstrb hold their last values.

Response:
- In RESP, the owner's rvalid=1 and its rdata is m_rdata passed through combinationally.
- For a store, d_rvalid=1 and d_rdata=0. The non-owner's rvalid is 0.

Arbitration:
- Only one requester present: it wins.
- Both present: d_req wins (fixed priority), unless ARB_RR_EN is defined.

Requester rules:
- A requester must hold req and its payload stable until it sees gnt.
- It may deassert req, or present the next request, in the cycle after gnt.
- A request that goes unanswered is never dropped.

Reset:
- Asserting reset at any time returns the block to IDLE and clears the counter, the owner bit and the last-grant bit.
- Any in-flight response is discarded and no rvalid is produced.
- Reset values of all outputs are 0: i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, m_addr, m_wdata, m_wstrb, busy, i_rdata and d_rdata.

## Timing
- A grant in cycle t gives ISSUE (m_en=1) in cycle t+1 and RESP (rvalid) in cycle t+1+MEM_LAT.
- Back-to-back throughput is one transaction per MEM_LAT+1 cycles: a grant in RESP overlaps the previous transaction's response.
- The memory must present valid m_rdata exactly MEM_LAT cycles after the m_en cycle. The arbiter does not register m_rdata.
- busy=1 from cycle t+1 through t+1+MEM_LAT inclusive. It stays 1 only if the next transaction is granted in RESP.
- Request asserted in the same cycle as RESP: granted in that cycle with no idle bubble.

## Configuration
- ARB_RR_EN defined: a last-grant register is added. It is updated on every grant and reset to "data".
  - On conflict, the requester that was not granted last wins.
  - Under continuous conflict, grants alternate fetch, data, fetch, … starting with fetch.
- ARB_RR_EN undefined: there is no last-grant register. Data always wins on conflict, and fetch may starve while d_req stays high.

## Test plan
- Single fetch, MEM_LAT=2: i_req in cycle 0 with i_addr=0x100.
  - Required: i_gnt in cycle 0; m_en=1, m_we=0, m_addr=0x100 in cycle 1.
  - Memory drives 0xDEADBEEF in cycle 3. Required: i_rvalid=1, i_rdata=0xDEADBEEF in cycle 3; busy=1 in cycles 1–3.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678, d_wstrb=0xF.
  - Required: m_en=1, m_we=1 with those values one cycle after d_gnt.
  - Required: d_rvalid=1, d_rdata=0 in cycle 3.
  - Required: i_rvalid stays 0 throughout.
- Conflict, fixed priority: i_req and d_req both held high for 20 cycles.
  - Required: every grant goes to data and i_gnt never asserts.
  - Required: grants occur every 3 cycles (cycles 0, 3, 6, …).
- Conflict with ARB_RR_EN: same stimulus.
  - Required: grant order is fetch, data, fetch, data.
  - Required: each rvalid goes to the matching owner three cycles after its grant.
- Reset mid-transaction: assert reset during WAIT (cycle 2 of a load).
  - Required: all outputs 0 immediately, with no rvalid.
  - After release with i_req held: a new grant in the first cycle out of reset.
- MEM_LAT=1 back-to-back fetches at 0x0, 0x4, 0x8.
  - Required: grants in cycles 0, 2 and 4; rvalid in cycles 2, 4 and 6; m_en never asserted in two consecutive cycles.
